// File: rtl/cmp_nic.sv
// NIC between one CMP processor node and its ring router port: one-packet input/output buffers.
// Optional build macro NIC_VC_POLARITY_EN gates sending on the packet VC bit matching net_polarity.
module cmp_nic #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [0:1]        addr_nic,
    input  logic [0:DATA_W-1] din_nic,
    output logic [0:DATA_W-1] dout_nic,
    input  logic              nicEn,
    input  logic              nicWrEn,
    input  logic              net_si,
    output logic              net_ri,
    input  logic [0:DATA_W-1] net_di,
    output logic              net_so,
    input  logic              net_ro,
    output logic [0:DATA_W-1] net_do,
    input  logic              net_polarity
);

    localparam logic [1:0] AddrInBuf   = 2'b00;
    localparam logic [1:0] AddrInStat  = 2'b01;
    localparam logic [1:0] AddrOutBuf  = 2'b10;
    localparam logic [1:0] AddrOutStat = 2'b11;

    logic [0:DATA_W-1] in_buf;
    logic [0:DATA_W-1] out_buf;
    logic              in_full;
    logic              out_full;
    logic              rd_en;
    logic              wr_out;
    logic              vc_ok;

    assign rd_en  = nicEn & ~nicWrEn;
    assign wr_out = nicEn & nicWrEn & (addr_nic == AddrOutBuf);

`ifdef NIC_VC_POLARITY_EN
    assign vc_ok = (out_buf[0] == net_polarity);
`else
    logic unused_polarity;
    assign unused_polarity = net_polarity;
    assign vc_ok = 1'b1;
`endif

    assign net_ri = ~in_full;
    assign net_so = out_full & net_ro & vc_ok;
    assign net_do = out_buf;

    always_ff @(posedge clk) begin
        if (reset) begin
            in_buf   <= '0;
            out_buf  <= '0;
            in_full  <= 1'b0;
            out_full <= 1'b0;
            dout_nic <= '0;
        end else begin
            // Accept only happens while empty, so it never collides with the read-clear.
            if (net_si && net_ri) begin
                in_buf  <= net_di;
                in_full <= 1'b1;
            end else if (rd_en && addr_nic == AddrInBuf && in_full) begin
                in_full <= 1'b0;
            end

            if (rd_en) begin
                unique case (addr_nic)
                    AddrInBuf:   dout_nic <= in_buf;
                    AddrInStat:  dout_nic <= {{(DATA_W-1){1'b0}}, in_full};
                    AddrOutBuf:  dout_nic <= '0;
                    AddrOutStat: dout_nic <= {{(DATA_W-1){1'b0}}, out_full};
                    default:     dout_nic <= '0;
                endcase
            end

            // A write landing on the drain edge sees the old full flag and is dropped.
            if (net_so) begin
                out_full <= 1'b0;
            end else if (wr_out && !out_full) begin
                out_buf  <= din_nic;
                out_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cmp_nic.sv
// Self-checking bench for cmp_nic: directed steps then randomized traffic against a queue model.
module tb_cmp_nic;

    logic        clk = 1'b0;
    logic        reset, nicEn, nicWrEn, net_si, net_ri, net_so, net_ro, net_polarity;
    logic [1:0]  addr_nic;
    logic [63:0] din_nic, dout_nic, net_di, net_do;

    int checks = 0;
    int errors = 0;

    // Model: each channel is a queue of at most one packet plus the last data written into it.
    logic [63:0] in_q[$];
    logic [63:0] out_q[$];
    logic [63:0] m_in_buf  = '0;
    logic [63:0] m_out_buf = '0;
    logic [63:0] m_dout    = '0;

    logic        s_so, s_ri;
    logic [63:0] s_do;

    cmp_nic #(.DATA_W(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .addr_nic     (addr_nic),
        .din_nic      (din_nic),
        .dout_nic     (dout_nic),
        .nicEn        (nicEn),
        .nicWrEn      (nicWrEn),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_polarity (net_polarity)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_send(input logic ro);
        logic ok;
        if (out_q.size() == 0 || !ro) return 1'b0;
        ok = 1'b1;
`ifdef NIC_VC_POLARITY_EN
        ok = (out_q[0][63] == net_polarity);
`endif
        return ok;
    endfunction

    // One clock cycle: drive, check settled outputs, advance the model across the edge.
    task automatic cyc(input logic rst, input logic en, input logic wr, input logic [1:0] a,
                       input logic [63:0] d, input logic si, input logic [63:0] di,
                       input logic ro, input logic pol);
        logic send, acc, wr_ok;
        reset = rst; nicEn = en; nicWrEn = wr; addr_nic = a; din_nic = d;
        net_si = si; net_di = di; net_ro = ro; net_polarity = pol;
        #3;
        s_so = net_so; s_ri = net_ri; s_do = net_do;
        chk("net_ri", {63'b0, net_ri}, {63'b0, in_q.size() == 0});
        chk("net_so", {63'b0, net_so}, {63'b0, exp_send(ro)});
        chk("net_do", net_do, m_out_buf);
        chk("dout_nic", dout_nic, m_dout);
        if (rst) begin
            in_q.delete(); out_q.delete();
            m_in_buf = '0; m_out_buf = '0; m_dout = '0;
        end else begin
            send  = exp_send(ro);
            acc   = si && in_q.size() == 0;
            wr_ok = en && wr && a == 2'd2 && out_q.size() == 0;
            if (en && !wr) begin
                case (a)
                    2'd0: begin
                        m_dout = m_in_buf;
                        if (in_q.size() != 0) void'(in_q.pop_front());
                    end
                    2'd1: m_dout = {63'b0, in_q.size() != 0};
                    2'd2: m_dout = '0;
                    default: m_dout = {63'b0, out_q.size() != 0};
                endcase
            end
            if (acc) begin
                in_q.push_back(di);
                m_in_buf = di;
            end
            if (send) void'(out_q.pop_front());
            if (wr_ok) begin
                out_q.push_back(d);
                m_out_buf = d;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ro, input logic pol);
        cyc(1'b0, 1'b0, 1'b0, 2'd0, '0, 1'b0, '0, ro, pol);
    endtask

    task automatic rd(input logic [1:0] a);
        cyc(1'b0, 1'b1, 1'b0, a, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [63:0] d, input logic ro, input logic pol);
        cyc(1'b0, 1'b1, 1'b1, 2'd2, d, 1'b0, '0, ro, pol);
    endtask

    initial begin
        // Unchecked first edge so the DUT leaves its unknown power-up state.
        reset = 1'b1; nicEn = 1'b0; nicWrEn = 1'b0; addr_nic = '0; din_nic = '0;
        net_si = 1'b0; net_di = '0; net_ro = 1'b0; net_polarity = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        cyc(1'b1, 1'b0, 1'b0, 2'd0, '0, 1'b0, '0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 2'd0, '0, 1'b0, '0, 1'b0, 1'b0);
        chk("rst_ri", {63'b0, net_ri}, 64'h1);
        chk("rst_so", {63'b0, net_so}, 64'h0);
        rd(2'd1);
        chk("rst_in_stat", dout_nic, 64'h0);
        rd(2'd3);
        chk("rst_out_stat", dout_nic, 64'h0);

        // Input channel
        cyc(1'b0, 1'b0, 1'b0, 2'd0, '0, 1'b1, 64'h8000_0000_DEAD_BEEF, 1'b0, 1'b0);
        rd(2'd1);
        chk("ri_falls", {63'b0, s_ri}, 64'h0);
        chk("in_stat_full", dout_nic, 64'h1);
        rd(2'd0);
        chk("in_buf_read", dout_nic, 64'h8000_0000_DEAD_BEEF);
        rd(2'd1);
        chk("in_stat_clear", dout_nic, 64'h0);
        chk("ri_back", {63'b0, s_ri}, 64'h1);
        rd(2'd0);
        chk("in_buf_stale", dout_nic, 64'h8000_0000_DEAD_BEEF);
        rd(2'd2);
        chk("rd_out_buf_zero", dout_nic, 64'h0);

        // Output channel, VC 0
        wr(64'h0000_0000_1234_5678, 1'b1, 1'b0);
        chk("so_before", {63'b0, s_so}, 64'h0);
        idle(1'b1, 1'b0);
        chk("so_vc0", {63'b0, s_so}, 64'h1);
        chk("do_vc0", s_do, 64'h0000_0000_1234_5678);
        idle(1'b1, 1'b0);
        chk("so_once", {63'b0, s_so}, 64'h0);
        rd(2'd3);
        chk("out_stat_drained", dout_nic, 64'h0);

        // Output channel, VC 1 with polarity 0
        wr(64'h8000_0000_0000_0001, 1'b1, 1'b0);
        idle(1'b1, 1'b0);
`ifdef NIC_VC_POLARITY_EN
        chk("so_vc1_blocked", {63'b0, s_so}, 64'h0);
        idle(1'b1, 1'b1);
        chk("so_vc1_pol1", {63'b0, s_so}, 64'h1);
`else
        chk("so_vc1_nopol", {63'b0, s_so}, 64'h1);
`endif
        chk("do_vc1", s_do, 64'h8000_0000_0000_0001);

        // Second write while full is dropped
        wr(64'h0000_0000_AAAA_0001, 1'b0, 1'b0);
        wr(64'h0000_0000_BBBB_0002, 1'b0, 1'b0);
        idle(1'b1, 1'b0);
        chk("so_first", {63'b0, s_so}, 64'h1);
        chk("do_first", s_do, 64'h0000_0000_AAAA_0001);
        idle(1'b1, 1'b0);
        chk("no_second", {63'b0, s_so}, 64'h0);

        // Reset with both buffers full
        wr(64'h0000_0000_C0DE_0003, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 2'd0, '0, 1'b1, 64'h0000_0000_0000_0042, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 2'd0, '0, 1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 2'd1, '0, 1'b0, '0, 1'b1, 1'b0);
        chk("rst_mid_so", {63'b0, s_so}, 64'h0);
        chk("rst_mid_ri", {63'b0, s_ri}, 64'h1);
        chk("rst_mid_in_stat", dout_nic, 64'h0);
        rd(2'd3);
        chk("rst_mid_out_stat", dout_nic, 64'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 79) == 0),
                1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)),
                {$urandom, $urandom},
                1'($urandom_range(0, 1)),
                {$urandom, $urandom},
                1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
